spi_cmd_arbiter: RTL and testbench

//  Shares the single adc_spi register-access engine between NUM_REQ requesters:

---
 rtl/spi_cmd_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_spi_cmd_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_arbiter.sv
// Round-robin arbiter sharing one adc_spi register-access engine between NUM_REQ requesters.
// One transaction in flight at a time; a watchdog completes a hung transaction with an error.
module spi_cmd_arbiter #(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic                      req_err,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      busy,
    output logic [2:0]                grant_id,
    output logic                      timeout_flag,
    output logic                      cmd_read,
    output logic                      cmd_write,
    input  logic                      cmd_read_ack,
    input  logic                      cmd_write_ack,
    output logic [ADDR_W-1:0]         cmd_addr,
    output logic [DATA_W-1:0]         cmd_wdata,
    input  logic [DATA_W-1:0]         cmd_rdata
);

    typedef enum logic [1:0] {StIdle, StBusy, StHold} state_e;

    state_e              state_q, state_d;
    logic [2:0]          last_grant_q, last_grant_d;
    logic [2:0]          grant_id_q, grant_id_d;
    logic                cmd_read_q, cmd_read_d;
    logic                cmd_write_q, cmd_write_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic [NUM_REQ-1:0]  req_ack_q, req_ack_d;
    logic                req_err_q, req_err_d;
    logic [DATA_W-1:0]   req_rdata_q, req_rdata_d;
    logic                timeout_q, timeout_d;
    logic [15:0]         wd_q, wd_d;

    logic [7:0]          req_pad;
    logic [3:0]          cand;
    logic                pick_valid;
    logic [2:0]          pick_idx;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [NUM_REQ-1:0]  grant_onehot;
    logic                ack_match;

    // Scan from last_grant+1 upward, wrapping; cand never exceeds 2*NUM_REQ-1.
    always_comb begin
        req_pad    = 8'(req);
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant_q} + 4'(k);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            if (!pick_valid && req_pad[cand[2:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[2:0];
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == 3'(i)) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            grant_onehot[i] = (grant_id_q == 3'(i));
        end
    end

    // Only the ack matching the issued command type counts.
    assign ack_match = (cmd_write_q && cmd_write_ack) || (cmd_read_q && cmd_read_ack);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        cmd_read_d   = cmd_read_q;
        cmd_write_d  = cmd_write_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        req_ack_d    = '0;
        req_err_d    = 1'b0;
        req_rdata_d  = req_rdata_q;
        timeout_d    = timeout_q;
        wd_d         = wd_q;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_id_d   = pick_idx;
                    last_grant_d = pick_idx;
                    cmd_addr_d   = sel_addr;
                    cmd_wdata_d  = sel_wdata;
                    cmd_write_d  = sel_we;
                    cmd_read_d   = !sel_we;
                    wd_d         = '0;
                    state_d      = StBusy;
                end
            end
            StBusy: begin
                if (ack_match) begin
                    cmd_read_d  = 1'b0;
                    cmd_write_d = 1'b0;
                    req_ack_d   = grant_onehot;
                    if (cmd_read_q) begin
                        req_rdata_d = cmd_rdata;
                    end
                    state_d = StHold;
                end else if (wd_q == 16'(TIMEOUT_CYC - 1)) begin
                    cmd_read_d  = 1'b0;
                    cmd_write_d = 1'b0;
                    req_ack_d   = grant_onehot;
                    req_err_d   = 1'b1;
                    timeout_d   = 1'b1;
                    state_d     = StHold;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            StHold: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 3'(NUM_REQ - 1);
            grant_id_q   <= '0;
            cmd_read_q   <= 1'b0;
            cmd_write_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            req_ack_q    <= '0;
            req_err_q    <= 1'b0;
            req_rdata_q  <= '0;
            timeout_q    <= 1'b0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            cmd_read_q   <= cmd_read_d;
            cmd_write_q  <= cmd_write_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            req_ack_q    <= req_ack_d;
            req_err_q    <= req_err_d;
            req_rdata_q  <= req_rdata_d;
            timeout_q    <= timeout_d;
            wd_q         <= wd_d;
        end
    end

    assign req_ack      = req_ack_q;
    assign req_err      = req_err_q;
    assign req_rdata    = req_rdata_q;
    assign busy         = (state_q != StIdle);
    assign grant_id     = grant_id_q;
    assign timeout_flag = timeout_q;
    assign cmd_read     = cmd_read_q;
    assign cmd_write    = cmd_write_q;
    assign cmd_addr     = cmd_addr_q;
    assign cmd_wdata    = cmd_wdata_q;

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Scoreboard bench for spi_cmd_arbiter: stimulus pushes expected commands and acks,
// two monitors pop and compare whenever the DUT issues a command or a req_ack.
module tb_spi_cmd_arbiter;

    localparam int unsigned NR = 3;
    localparam int unsigned AW = 13;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 100;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [2:0]    gid;
        int            gap;
    } cmd_item_t;

    typedef struct {
        logic [NR-1:0] ack;
        logic          err;
        logic [DW-1:0] rdata;
        bit            chk_rd;
    } ack_item_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR-1:0]     req_we = '0;
    logic [AW-1:0]     addr_tab [NR];
    logic [DW-1:0]     wdata_tab [NR];
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_ack;
    logic              req_err;
    logic [DW-1:0]     req_rdata;
    logic              busy;
    logic [2:0]        grant_id;
    logic              timeout_flag;
    logic              cmd_read;
    logic              cmd_write;
    logic              cmd_read_ack = 1'b0;
    logic              cmd_write_ack = 1'b0;
    logic [AW-1:0]     cmd_addr;
    logic [DW-1:0]     cmd_wdata;
    logic [DW-1:0]     cmd_rdata = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    cmd_item_t exp_cmd[$];
    ack_item_t exp_ack[$];

    assign req_addr  = {addr_tab[2], addr_tab[1], addr_tab[0]};
    assign req_wdata = {wdata_tab[2], wdata_tab[1], wdata_tab[0]};

    spi_cmd_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ack      (req_ack),
        .req_err      (req_err),
        .req_rdata    (req_rdata),
        .busy         (busy),
        .grant_id     (grant_id),
        .timeout_flag (timeout_flag),
        .cmd_read     (cmd_read),
        .cmd_write    (cmd_write),
        .cmd_read_ack (cmd_read_ack),
        .cmd_write_ack(cmd_write_ack),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_rdata    (cmd_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_we[id]    = we;
        addr_tab[id]  = a;
        wdata_tab[id] = d;
    endtask

    task automatic expect_cmd(input int g, input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input int gap);
        cmd_item_t c;
        c.we = we; c.addr = a; c.wdata = d; c.gid = 3'(g); c.gap = gap;
        exp_cmd.push_back(c);
    endtask

    task automatic expect_ack(input int g, input logic err, input logic [DW-1:0] rd,
                              input bit chk);
        ack_item_t k;
        k.ack = '0;
        k.ack[g] = 1'b1;
        k.err = err; k.rdata = rd; k.chk_rd = chk;
        exp_ack.push_back(k);
    endtask

    task automatic expect_txn(input int g, input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input int gap, input logic err,
                              input logic [DW-1:0] rd, input bit chk);
        expect_cmd(g, we, a, d, gap);
        expect_ack(g, err, rd, chk);
    endtask

    // Counts negedges until a command is seen; 2 means issued one cycle after req is sampled.
    task automatic wait_cmd(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(cmd_read || cmd_write) && n < 50);
        check("cmd_seen", cmd_read || cmd_write, 1'b1);
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        while (req_ack == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ack_seen", req_ack != '0, 1'b1);
    endtask

    task automatic finish_req(input logic [NR-1:0] mask);
        wait_ack();
        @(posedge clk); #1;
        req = req & ~mask;
    endtask

    task automatic eng_respond(input bit wr, input int dly, input logic [DW-1:0] rd);
        repeat (dly) @(posedge clk);
        #1;
        if (wr) cmd_write_ack = 1'b1;
        else    cmd_read_ack  = 1'b1;
        cmd_rdata = rd;
        @(posedge clk); #1;
        cmd_write_ack = 1'b0;
        cmd_read_ack  = 1'b0;
        cmd_rdata     = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_read"}, cmd_read, 0);
        check({tag, "_cmd_write"}, cmd_write, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_req_ack"}, req_ack, 0);
        check({tag, "_req_err"}, req_err, 0);
        check({tag, "_grant_id"}, grant_id, 0);
        check({tag, "_timeout_flag"}, timeout_flag, 0);
        check({tag, "_req_rdata"}, req_rdata, 0);
        check({tag, "_cmd_addr"}, cmd_addr, 0);
        check({tag, "_cmd_wdata"}, cmd_wdata, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        cmd_read_ack = 1'b0;
        cmd_write_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Command monitor: compares each newly issued engine command and the idle gap before it.
    initial begin
        cmd_item_t e;
        logic prev;
        logic act;
        int fall_cyc;
        prev = 1'b0;
        fall_cyc = -1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
                fall_cyc = -1;
            end else begin
                act = cmd_read | cmd_write;
                if (prev && !act) fall_cyc = cyc;
                if (!prev && act) begin
                    if (exp_cmd.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL cmd_unexpected: got grant %0d addr 0x%0h, expected none",
                                 grant_id, cmd_addr);
                    end else begin
                        e = exp_cmd.pop_front();
                        check("cmd_write", cmd_write, e.we);
                        check("cmd_read", cmd_read, !e.we);
                        check("cmd_addr", cmd_addr, e.addr);
                        if (e.we) check("cmd_wdata", cmd_wdata, e.wdata);
                        check("grant_id", grant_id, e.gid);
                        if (e.gap >= 0) check("idle_gap", cyc - fall_cyc, e.gap);
                    end
                end
                prev = act;
            end
        end
    end

    // Ack monitor: every req_ack pulse must match the next expected completion.
    initial begin
        ack_item_t k;
        forever begin
            @(negedge clk);
            if (!rst && req_ack != '0) begin
                if (exp_ack.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL ack_unexpected: got req_ack 0x%0h, expected none", req_ack);
                end else begin
                    k = exp_ack.pop_front();
                    check("req_ack", req_ack, k.ack);
                    check("req_err", req_err, k.err);
                    if (k.chk_rd) check("req_rdata", req_rdata, k.rdata);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        logic we2 [NR];
        for (int i = 0; i < int'(NR); i++) begin
            addr_tab[i]  = '0;
            wdata_tab[i] = '0;
        end
        do_reset();

        // 1: single write from requester 0, engine acks after 40 cycles
        @(posedge clk); #1;
        set_req(0, 1'b1, 13'h0014, 8'h5A);
        expect_txn(0, 1'b1, 13'h0014, 8'h5A, -1, 1'b0, 8'h00, 1'b0);
        req = 3'b001;
        wait_cmd(n);
        check("t1_cmd_latency", n, 2);
        check("t1_busy", busy, 1);
        eng_respond(1'b1, 40, 8'h00);
        finish_req(3'b001);
        repeat (3) @(posedge clk);

        // 2: all requesters held, round-robin 0,1,2,0,1,2 with two idle cycles between
        do_reset();
        we2[0] = 1'b1; we2[1] = 1'b0; we2[2] = 1'b1;
        for (int i = 0; i < int'(NR); i++) begin
            set_req(i, we2[i], 13'(13'h0100 + i), 8'(8'h10 + i));
        end
        for (int i = 0; i < 6; i++) begin
            expect_txn(i % 3, we2[i % 3], 13'(13'h0100 + i % 3), 8'(8'h10 + i % 3),
                       (i == 0) ? -1 : 2, 1'b0, 8'(8'hC0 + i), !we2[i % 3]);
        end
        @(posedge clk); #1;
        req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            wait_cmd(n);
            eng_respond(we2[i % 3], 3, 8'(8'hC0 + i));
            wait_ack();
            @(posedge clk); #1;
            if (i == 5) begin
                req = '0;
            end else begin
                req[i % 3] = 1'b0;
                @(posedge clk); #1;
                req[i % 3] = 1'b1;
            end
        end
        repeat (3) @(posedge clk);

        // 3: read by requester 1, data held after the ack
        #1;
        set_req(1, 1'b0, 13'h001F, 8'h00);
        expect_txn(1, 1'b0, 13'h001F, 8'h00, -1, 1'b0, 8'hA5, 1'b1);
        req = 3'b010;
        wait_cmd(n);
        eng_respond(1'b0, 4, 8'hA5);
        finish_req(3'b010);
        repeat (3) @(negedge clk);
        check("t3_rdata_held", req_rdata, 8'hA5);

        // 4: engine never acks a read -> error ack after TO busy cycles, rdata untouched
        @(posedge clk); #1;
        cmd_rdata = 8'h3C;
        set_req(2, 1'b0, 13'h0ABC, 8'h00);
        expect_txn(2, 1'b0, 13'h0ABC, 8'h00, -1, 1'b1, 8'hA5, 1'b1);
        req = 3'b100;
        wait_cmd(n);
        n = 1;
        while ((cmd_read || cmd_write) && n < 300) begin
            @(negedge clk);
            if (cmd_read || cmd_write) n++;
        end
        check("t4_busy_cycles", n, TO);
        finish_req(3'b100);
        cmd_rdata = '0;
        check("t4_timeout_flag", timeout_flag, 1);
        @(posedge clk); #1;
        set_req(0, 1'b1, 13'h0001, 8'hEE);
        expect_txn(0, 1'b1, 13'h0001, 8'hEE, -1, 1'b0, 8'h00, 1'b0);
        req = 3'b001;
        wait_cmd(n);
        eng_respond(1'b1, 2, 8'h00);
        finish_req(3'b001);
        check("t4_timeout_sticky", timeout_flag, 1);

        // 5: wrong-type ack ignored; then ack landing on the timeout cycle wins
        @(posedge clk); #1;
        cmd_rdata = 8'h11;
        set_req(0, 1'b0, 13'h0033, 8'h00);
        expect_txn(0, 1'b0, 13'h0033, 8'h00, -1, 1'b0, 8'h77, 1'b1);
        req = 3'b001;
        wait_cmd(n);
        repeat (5) @(posedge clk);
        #1 cmd_write_ack = 1'b1;
        @(posedge clk);
        #1 cmd_write_ack = 1'b0;
        check("t5_still_reading", cmd_read, 1);
        eng_respond(1'b0, 5, 8'h77);
        finish_req(3'b001);
        @(posedge clk); #1;
        set_req(1, 1'b0, 13'h0044, 8'h00);
        expect_txn(1, 1'b0, 13'h0044, 8'h00, -1, 1'b0, 8'h99, 1'b1);
        req = 3'b010;
        wait_cmd(n);
        eng_respond(1'b0, TO - 1, 8'h99);
        finish_req(3'b010);

        // 6: async reset mid-transaction, then requester 0 wins first
        @(posedge clk); #1;
        set_req(2, 1'b1, 13'h0055, 8'h66);
        expect_cmd(2, 1'b1, 13'h0055, 8'h66, -1);
        req = 3'b100;
        wait_cmd(n);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_all_zero("t6_async");
        req = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        set_req(0, 1'b1, 13'h0101, 8'h12);
        set_req(1, 1'b0, 13'h0202, 8'h00);
        expect_txn(0, 1'b1, 13'h0101, 8'h12, -1, 1'b0, 8'h00, 1'b0);
        expect_txn(1, 1'b0, 13'h0202, 8'h00, 2, 1'b0, 8'h3E, 1'b1);
        req = 3'b011;
        wait_cmd(n);
        check("t6_cmd_latency", n, 2);
        eng_respond(1'b1, 2, 8'h00);
        finish_req(3'b001);
        wait_cmd(n);
        eng_respond(1'b0, 2, 8'h3E);
        finish_req(3'b010);

        repeat (5) @(posedge clk);
        check("cmd_queue_drained", exp_cmd.size(), 0);
        check("ack_queue_drained", exp_ack.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
